// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection for the fetch stage. It sequences boot after reset,
// handles branch/jump/trap/mret redirects with a timed flush, load-use stalls and debug halt.
module pc_sequencer #(
    parameter int unsigned     BITS         = 64,
    parameter logic [BITS-1:0] RESET_VECTOR = '0,
    parameter logic [BITS-1:0] TRAP_VECTOR  = BITS'('h100),
    parameter int unsigned     BOOT_CYCLES  = 2,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] pc_cur,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [BITS-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [BITS-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [BITS-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [BITS-1:0] pc_next_o,
    output logic            pc_we_o,
    output logic            flush_o,
    output logic [BITS-1:0] epc_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_CNT  = 8'(BOOT_CYCLES);
    localparam logic [7:0] FLUSH_CNT = 8'(FLUSH_CYCLES - 1);
    // A single-cycle flush is fully covered by the redirect cycle itself.
    localparam state_t REDIRECT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nx;
    logic [BITS-1:0] epc;
    logic            epc_load;
    logic            redirect;
    logic [BITS-1:0] target;
    logic [BITS-1:0] seq_pc;

    assign seq_pc  = pc_cur + BITS'(4);
    assign epc_o   = epc;
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            cnt   <= BOOT_CNT;
            epc   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (epc_load) begin
                epc <= trap_pc_i;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        epc_load  = 1'b0;
        redirect  = 1'b0;
        target    = pc_cur;
        pc_next_o = pc_cur;
        pc_we_o   = 1'b0;
        flush_o   = 1'b0;

        case (state)
            BOOT: begin
                flush_o   = 1'b1;
                pc_next_o = RESET_VECTOR;
                cnt_nx    = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    pc_we_o  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (trap_i) begin
                    redirect = 1'b1;
                    target   = TRAP_VECTOR;
                    epc_load = 1'b1;
                end else if (mret_i) begin
                    redirect = 1'b1;
                    target   = epc;
                end else if (branch_i) begin
                    redirect = 1'b1;
                    target   = branch_target_i;
                end else if (jump_i) begin
                    redirect = 1'b1;
                    target   = jump_target_i;
                end else if (halt_i) begin
                    state_nx = HALT;
                end else if (!stall_i) begin
                    pc_next_o = seq_pc;
                    pc_we_o   = 1'b1;
                end
            end
            FLUSH: begin
                flush_o   = 1'b1;
                pc_we_o   = 1'b1;
                pc_next_o = seq_pc;
                // cnt counts remaining flush cycles including this one.
                if (trap_i) begin
                    redirect = 1'b1;
                    target   = TRAP_VECTOR;
                    epc_load = 1'b1;
                end else if (cnt <= 8'd1) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            HALT: begin
                if (trap_i) begin
                    redirect = 1'b1;
                    target   = TRAP_VECTOR;
                    epc_load = 1'b1;
                end else if (resume_i) begin
                    state_nx = RUN;
                end
            end
        endcase

        if (redirect) begin
            pc_next_o = target;
            pc_we_o   = 1'b1;
            flush_o   = 1'b1;
            state_nx  = REDIRECT_STATE;
            cnt_nx    = FLUSH_CNT;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed test-plan scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned BOOT  = 2;
    localparam int unsigned FLUSH = 2;
    localparam logic [63:0] RV    = 64'h1000;
    localparam logic [63:0] TV    = 64'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_cur;
    logic        stall_i, branch_i, jump_i, trap_i, mret_i, halt_i, resume_i;
    logic [63:0] branch_target_i, jump_target_i, trap_pc_i;
    logic [63:0] pc_next_o, epc_o;
    logic        pc_we_o, flush_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining boot/flush cycles, halted flag, saved trap PC.
    int          boot_left;
    int          flush_left;
    bit          halted;
    logic [63:0] m_epc;

    pc_sequencer #(
        .BITS(64),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .BOOT_CYCLES(BOOT),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_cur(pc_cur),
        .stall_i(stall_i),
        .branch_i(branch_i),
        .branch_target_i(branch_target_i),
        .jump_i(jump_i),
        .jump_target_i(jump_target_i),
        .trap_i(trap_i),
        .trap_pc_i(trap_pc_i),
        .mret_i(mret_i),
        .halt_i(halt_i),
        .resume_i(resume_i),
        .pc_next_o(pc_next_o),
        .pc_we_o(pc_we_o),
        .flush_o(flush_o),
        .epc_o(epc_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: evaluates the model on every negedge and checks all outputs.
    always @(negedge clk) begin
        logic [63:0] e_pc, e_epc, tgt;
        logic        e_we, e_flush, e_pc_valid, redir;
        logic [1:0]  e_state;
        e_pc_valid = 1'b1;
        redir      = 1'b0;
        tgt        = '0;
        if (rst) begin
            boot_left  = BOOT;
            flush_left = 0;
            halted     = 0;
            m_epc      = '0;
            e_state = 2'd0; e_we = 1'b0; e_flush = 1'b1; e_pc = RV; e_epc = '0;
        end else begin
            e_epc = m_epc;
            if (boot_left > 0) begin
                e_state = 2'd0; e_flush = 1'b1; e_pc = RV;
                e_we    = (boot_left == 1);
                boot_left--;
            end else if (flush_left > 0) begin
                e_state = 2'd2; e_flush = 1'b1; e_we = 1'b1; e_pc = pc_cur + 64'd4;
                if (trap_i) begin redir = 1'b1; tgt = TV; end
                else flush_left--;
            end else if (halted) begin
                e_state = 2'd3; e_flush = 1'b0; e_we = 1'b0; e_pc = pc_cur;
                if (trap_i) begin redir = 1'b1; tgt = TV; end
                else if (resume_i) halted = 0;
            end else begin
                e_state = 2'd1; e_flush = 1'b0;
                if (trap_i)        begin redir = 1'b1; tgt = TV; end
                else if (mret_i)   begin redir = 1'b1; tgt = m_epc; end
                else if (branch_i) begin redir = 1'b1; tgt = branch_target_i; end
                else if (jump_i)   begin redir = 1'b1; tgt = jump_target_i; end
                else if (halt_i)   begin e_we = 1'b0; e_pc_valid = 1'b0; e_pc = '0; halted = 1; end
                else if (stall_i)  begin e_we = 1'b0; e_pc = pc_cur; end
                else               begin e_we = 1'b1; e_pc = pc_cur + 64'd4; end
            end
            if (redir) begin
                e_pc = tgt; e_we = 1'b1; e_flush = 1'b1;
                flush_left = FLUSH - 1;
                halted     = 0;
                if (trap_i) m_epc = trap_pc_i;
            end
        end
        chk("model_state", {62'd0, state_o}, {62'd0, e_state});
        chk("model_we", {63'd0, pc_we_o}, {63'd0, e_we});
        chk("model_flush", {63'd0, flush_o}, {63'd0, e_flush});
        chk("model_epc", epc_o, e_epc);
        if (e_pc_valid) chk("model_pc_next", pc_next_o, e_pc);
    end

    task automatic idle();
        stall_i = 0; branch_i = 0; jump_i = 0; trap_i = 0; mret_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        pc_cur = '0; branch_target_i = '0; jump_target_i = '0; trap_pc_i = '0;

        // Reset state
        mid();
        chk("rst_state", {62'd0, state_o}, 64'd0);
        chk("rst_we", {63'd0, pc_we_o}, 64'd0);
        chk("rst_flush", {63'd0, flush_o}, 64'd1);
        chk("rst_pc_next", pc_next_o, 64'h1000);
        chk("rst_epc", epc_o, 64'd0);
        next_cycle();
        rst = 1'b0;

        // Boot: cycle 1 holds, cycle 2 writes the reset vector
        mid();
        chk("boot1_we", {63'd0, pc_we_o}, 64'd0);
        chk("boot1_flush", {63'd0, flush_o}, 64'd1);
        next_cycle();
        mid();
        chk("boot2_we", {63'd0, pc_we_o}, 64'd1);
        chk("boot2_pc", pc_next_o, 64'h1000);
        next_cycle();
        pc_cur = 64'h1000;
        mid();
        chk("run_state", {62'd0, state_o}, 64'd1);
        chk("run_seq", pc_next_o, 64'h1004);
        next_cycle();

        // Branch redirect, ignored branch during the flush cycle
        pc_cur = 64'h1008; branch_i = 1; branch_target_i = 64'h2000;
        mid();
        chk("br_pc", pc_next_o, 64'h2000);
        chk("br_flush", {63'd0, flush_o}, 64'd1);
        next_cycle();
        pc_cur = 64'h2000; branch_target_i = 64'h3000;
        mid();
        chk("br_fl_state", {62'd0, state_o}, 64'd2);
        chk("br_fl_pc", pc_next_o, 64'h2004);
        next_cycle();
        branch_i = 0;
        mid();
        chk("br_done_flush", {63'd0, flush_o}, 64'd0);
        next_cycle();

        // Load-use stall for three cycles
        pc_cur = 64'h40; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_we", {63'd0, pc_we_o}, 64'd0);
            chk("stall_pc", pc_next_o, 64'h40);
            next_cycle();
        end
        stall_i = 0;
        mid();
        chk("unstall_pc", pc_next_o, 64'h44);
        next_cycle();

        // Trap beats branch, then mret returns to the faulting PC
        trap_i = 1; branch_i = 1; trap_pc_i = 64'h3004; branch_target_i = 64'h2000;
        mid();
        chk("trap_pc", pc_next_o, 64'h100);
        next_cycle();
        trap_i = 0; branch_i = 0;
        mid();
        chk("trap_epc", epc_o, 64'h3004);
        next_cycle();
        next_cycle();
        mret_i = 1;
        mid();
        chk("mret_pc", pc_next_o, 64'h3004);
        chk("mret_flush", {63'd0, flush_o}, 64'd1);
        next_cycle();
        mret_i = 0;
        mid();
        chk("mret_flush2", {63'd0, flush_o}, 64'd1);
        next_cycle();
        mid();
        chk("mret_flush3", {63'd0, flush_o}, 64'd0);
        next_cycle();

        // Wraparound of the sequential increment
        pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
        mid();
        chk("wrap_pc", pc_next_o, 64'd0);
        next_cycle();

        // Halt, trap out of halt (beats resume), halt again and resume
        pc_cur = 64'h500; halt_i = 1;
        mid();
        chk("halt_we", {63'd0, pc_we_o}, 64'd0);
        next_cycle();
        halt_i = 0;
        mid();
        chk("halt_state", {62'd0, state_o}, 64'd3);
        chk("halt_pc", pc_next_o, 64'h500);
        next_cycle();
        trap_i = 1; resume_i = 1; trap_pc_i = 64'h5000;
        mid();
        chk("halt_trap_pc", pc_next_o, 64'h100);
        next_cycle();
        trap_i = 0; resume_i = 0;
        next_cycle();
        next_cycle();
        halt_i = 1;
        next_cycle();
        halt_i = 0; resume_i = 1;
        mid();
        chk("halt_resume_we", {63'd0, pc_we_o}, 64'd0);
        next_cycle();
        resume_i = 0;
        mid();
        chk("resume_state", {62'd0, state_o}, 64'd1);
        next_cycle();

        // Asynchronous reset in the middle of a flush
        jump_i = 1; jump_target_i = 64'h7000;
        next_cycle();
        jump_i = 0;
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_state", {62'd0, state_o}, 64'd0);
        chk("rstmid_we", {63'd0, pc_we_o}, 64'd0);
        chk("rstmid_pc", pc_next_o, 64'h1000);
        next_cycle();
        rst = 1'b0;

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(299) == 0);
            trap_i   = ($urandom_range(15) == 0);
            mret_i   = ($urandom_range(11) == 0);
            branch_i = ($urandom_range(5) == 0);
            jump_i   = ($urandom_range(5) == 0);
            halt_i   = ($urandom_range(15) == 0);
            resume_i = ($urandom_range(3) == 0);
            stall_i  = ($urandom_range(4) == 0);
            pc_cur   = ($urandom_range(9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            branch_target_i = {$urandom, $urandom};
            jump_target_i   = {$urandom, $urandom};
            trap_pc_i       = {$urandom, $urandom};
            next_cycle();
        end
        rst = 1'b0;
        idle();
        mid();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
